// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: issues one framebuffer RAM operation per cycle.
// A VGA pixel fetch takes every pix_tick slot. All other slots go round-robin
// to the drawing requesters. A small tag pipeline routes each returned read
// word to either the VGA path or the requester that issued it.
module framebuffer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 9,
  parameter int PIXEL_COUNT = 307200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_tick,
  input  logic [ADDR_WIDTH-1:0]         vga_addr,
  output logic [DATA_WIDTH-1:0]         vga_data,
  output logic                          vga_valid,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rvalid,
  output logic [$clog2(NUM_REQ)-1:0]    rvalid_id,
  output logic                          addr_err,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_wen,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0]       NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]     LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [ADDR_WIDTH:0] PIX_LIMIT = (ADDR_WIDTH+1)'(PIXEL_COUNT);

  // Routing information that travels with each issued operation.
  typedef struct packed {
    logic            vga;  // VGA pixel fetch
    logic            rd;   // requester read
    logic [ID_W-1:0] id;   // owning requester
    logic            err;  // out-of-range address, return zero
  } tag_t;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_wen_q, ram_wen_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  addr_err_q, addr_err_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  tag_t                  tag1_q, tag1_d, tag2_q;
  logic [DATA_WIDTH-1:0] vga_data_q, vga_data_d;
  logic                  vga_valid_q, vga_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_W-1:0]       rvalid_id_q, rvalid_id_d;

  // Unpack the flat requester buses into per-requester arrays.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [NUM_REQ-1:0]    eligible;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W:0]         scan_sum;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_oor;

  // Circular search for the first eligible requester at or after rr_ptr.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values just computed; clocked state always uses non-blocking '<='.
    eligible    = req & ~gnt_q;
    grant_found = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= NUM_REQ_W) scan_sum = scan_sum - NUM_REQ_W;
      if (!grant_found && eligible[scan_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_sum[ID_W-1:0];
      end
    end
  end

  assign sel_addr = addr_arr[grant_id];
  assign sel_oor  = ({1'b0, sel_addr} >= PIX_LIMIT);

  // Slot decision: VGA tick first, then round-robin grant, else idle.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    gnt_d       = '0;
    ram_addr_d  = ram_addr_q;
    ram_wen_d   = 1'b0;
    ram_wdata_d = ram_wdata_q;
    addr_err_d  = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    tag1_d      = '0;
    if (pix_tick) begin
      ram_addr_d = vga_addr;
      tag1_d.vga = 1'b1;
    end else if (grant_found) begin
      gnt_d[grant_id] = 1'b1;
      ram_addr_d      = sel_addr;
      ram_wdata_d     = wdata_arr[grant_id];
      ram_wen_d       = req_wen[grant_id] & ~sel_oor;
      addr_err_d      = sel_oor;
      tag1_d.rd       = ~req_wen[grant_id];
      tag1_d.id       = grant_id;
      tag1_d.err      = sel_oor;
      rr_ptr_d        = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Return path: steer ram_rdata using the tag that matches this cycle's data.
  always_comb begin
    vga_valid_d = tag2_q.vga;
    vga_data_d  = tag2_q.vga ? ram_rdata : vga_data_q;
    rvalid_d    = tag2_q.rd;
    rdata_d     = rdata_q;
    rvalid_id_d = rvalid_id_q;
    if (tag2_q.rd) begin
      rdata_d     = tag2_q.err ? '0 : ram_rdata;
      rvalid_id_d = tag2_q.id;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_wen_q   <= 1'b0;
      ram_wdata_q <= '0;
      addr_err_q  <= 1'b0;
      rr_ptr_q    <= '0;
      // NOTE: the tag pipeline is cleared so in-flight reads die with reset;
      // the RAM contents themselves are never reset.
      tag1_q      <= '0;
      tag2_q      <= '0;
      vga_data_q  <= '0;
      vga_valid_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      rvalid_id_q <= '0;
    end else begin
      gnt_q       <= gnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wen_q   <= ram_wen_d;
      ram_wdata_q <= ram_wdata_d;
      addr_err_q  <= addr_err_d;
      rr_ptr_q    <= rr_ptr_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      vga_data_q  <= vga_data_d;
      vga_valid_q <= vga_valid_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      rvalid_id_q <= rvalid_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wen   = ram_wen_q;
  assign ram_wdata = ram_wdata_q;
  assign addr_err  = addr_err_q;
  assign vga_data  = vga_data_q;
  assign vga_valid = vga_valid_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign rvalid_id = rvalid_id_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: synchronous RAM model, a transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_framebuffer_arbiter;
  localparam int NR = 4;
  localparam int AW = 19;
  localparam int DW = 9;
  localparam int PC = 307200;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pix_tick = 1'b0;
  logic [AW-1:0]     vga_addr = '0;
  logic [DW-1:0]     vga_data;
  logic              vga_valid;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_wen = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     gnt;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic [IW-1:0]     rvalid_id;
  logic              addr_err;
  logic [AW-1:0]     ram_addr;
  logic              ram_wen;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata = '0;

  always #5 clk = ~clk;

  framebuffer_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIXEL_COUNT(PC)) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .vga_addr(vga_addr),
    .vga_data(vga_data), .vga_valid(vga_valid), .req(req), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata),
    .rvalid(rvalid), .rvalid_id(rvalid_id), .addr_err(addr_err),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Framebuffer RAM: synchronous read, 1-cycle latency; junk beyond range.
  logic [DW-1:0] ram_mem [PC];
  always @(posedge clk) begin
    if (int'(ram_addr) < PC) begin
      if (ram_wen) ram_mem[int'(ram_addr)] <= ram_wdata;
      ram_rdata <= ram_mem[int'(ram_addr)];
    end else begin
      ram_rdata <= 9'h155;
    end
  end

  // Reference model: per-edge slot rule, expected read returns in a queue.
  typedef struct {
    int            due;
    bit            vga;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] shadow [PC];
  rd_t           pend [$];
  logic [NR-1:0] m_gnt = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_wen = 1'b0;
  logic          m_err = 1'b0;
  int            rr = 0;
  int            edge_n = 0;
  bit            live = 1'b0;
  bit            exp_vv = 1'b0;
  bit            exp_rv = 1'b0;
  logic [DW-1:0] exp_vdata = '0;
  logic [DW-1:0] exp_rdata = '0;
  int            exp_rid = 0;

  always @(posedge clk) begin
    int sel;
    int idx;
    logic [AW-1:0] a;
    logic oor;
    rd_t r;
    edge_n++;
    if (reset) begin
      m_gnt = '0; m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_err = 1'b0;
      rr = 0;
      pend.delete();
      live = 1'b1;
    end else begin
      m_wen = 1'b0;
      m_err = 1'b0;
      if (pix_tick) begin
        m_gnt  = '0;
        m_addr = vga_addr;
        r = '{due: edge_n + 2, vga: 1'b1, id: 0, data: shadow[int'(vga_addr)]};
        pend.push_back(r);
      end else begin
        sel = -1;
        for (int k = 0; k < NR; k++) begin
          idx = (rr + k) % NR;
          if (sel < 0 && req[idx] && !m_gnt[idx]) sel = idx;
        end
        m_gnt = '0;
        if (sel >= 0) begin
          m_gnt[sel] = 1'b1;
          a       = req_addr[sel*AW +: AW];
          oor     = (int'(a) >= PC);
          m_addr  = a;
          m_wdata = req_wdata[sel*DW +: DW];
          m_err   = oor;
          if (req_wen[sel]) begin
            if (!oor) begin
              m_wen = 1'b1;
              shadow[int'(a)] = m_wdata;
            end
          end else begin
            r = '{due: edge_n + 2, vga: 1'b0, id: sel, data: oor ? '0 : shadow[int'(a)]};
            pend.push_back(r);
          end
          rr = (sel + 1) % NR;
        end
      end
    end
    exp_vv = 1'b0;
    exp_rv = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      r = pend.pop_front();
      if (r.vga) begin
        exp_vv = 1'b1; exp_vdata = r.data;
      end else begin
        exp_rv = 1'b1; exp_rdata = r.data; exp_rid = r.id;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      check("cyc_gnt", 32'(gnt), 32'(m_gnt));
      check("cyc_ram_wen", 32'(ram_wen), 32'(m_wen));
      check("cyc_ram_addr", 32'(ram_addr), 32'(m_addr));
      check("cyc_addr_err", 32'(addr_err), 32'(m_err));
      if (m_wen) check("cyc_ram_wdata", 32'(ram_wdata), 32'(m_wdata));
      check("cyc_vga_valid", 32'(vga_valid), 32'(exp_vv));
      if (exp_vv) check("cyc_vga_data", 32'(vga_data), 32'(exp_vdata));
      check("cyc_rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv) begin
        check("cyc_rdata", 32'(rdata), 32'(exp_rdata));
        check("cyc_rvalid_id", 32'(rvalid_id), 32'(exp_rid));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise one request, wait for its grant, drop it in the cycle after.
  task automatic issue(input int id, input logic wen, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [NR-1:0] g_seen,
                       output logic err_seen, output logic wen_seen);
    logic got;
    req_wen[id] = wen;
    req_addr[id*AW +: AW] = a;
    req_wdata[id*DW +: DW] = d;
    req[id] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = gnt[id];
    end
    check("gnt_wait", 32'(got), 32'd1);
    g_seen = gnt; err_seen = addr_err; wen_seen = ram_wen;
    req[id] = 1'b0;
  endtask

  task automatic wait_rd(output logic [DW-1:0] d, output int id_o, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rvalid && lat < 10);
    check("rvalid_wait", 32'(rvalid), 32'd1);
    d = rdata; id_o = int'(rvalid_id);
  endtask

  logic [NR-1:0] g;
  logic          e, w;
  logic [DW-1:0] d;
  int            rid, lat, n_grant, viol, tick_gnt;
  int            order [40];
  int            lit [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    for (int i = 0; i < PC; i++) begin
      ram_mem[i] = 9'(i);
      shadow[i]  = 9'(i);
    end
    ram_mem[1000] = 9'h0A5;
    shadow[1000]  = 9'h0A5;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b0;

    // VGA fetch of pixel 1000.
    pix_tick = 1'b1; vga_addr = 19'd1000;
    @(negedge clk);
    check("vga_ram_addr", 32'(ram_addr), 32'd1000);
    check("vga_ram_wen", 32'(ram_wen), 32'd0);
    pix_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("vga_valid_c3", 32'(vga_valid), 32'd1);
    check("vga_data_c3", 32'(vga_data), 32'h0A5);

    // Write then read back by requester 2.
    issue(2, 1'b1, 19'd640, 9'h1FF, g, e, w);
    check("wr_gnt", 32'(g), 32'b0100);
    check("wr_wen", 32'(w), 32'd1);
    @(negedge clk);
    check("wr_ram", 32'(ram_mem[640]), 32'h1FF);
    issue(2, 1'b0, 19'd640, 9'h000, g, e, w);
    wait_rd(d, rid, lat);
    check("rd_data", 32'(d), 32'h1FF);
    check("rd_id", 32'(rid), 32'd2);
    check("rd_latency", 32'(lat), 32'd2);
    repeat (3) @(negedge clk);

    // All four requesting, tick every 4th slot.
    do_reset();
    req_wen = '0;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(100 + i);
    req = '1;
    n_grant = 0; tick_gnt = 0; viol = 0;
    for (int c = 0; c < 40; c++) begin
      pix_tick = (c % 4 == 0);
      vga_addr = AW'(3000 + c);
      @(negedge clk);
      if (pix_tick) begin
        if (gnt != '0) tick_gnt++;
      end else begin
        for (int i = 0; i < NR; i++) if (gnt[i]) begin
          order[n_grant] = i;
          n_grant++;
        end
      end
    end
    pix_tick = 1'b0;
    req = '0;
    for (int k = 0; k < 8; k++) check("rr_order", 32'(order[k]), 32'(lit[k]));
    for (int k = 1; k < n_grant; k++) if (order[k] == order[k-1]) viol++;
    check("rr_grants", 32'(n_grant), 32'd30);
    check("rr_tick_gnt", 32'(tick_gnt), 32'd0);
    check("rr_repeat", 32'(viol), 32'd0);
    repeat (4) @(negedge clk);

    // Tick and req[0] on the same edge.
    pix_tick = 1'b1; vga_addr = 19'd2000;
    req_wen[0] = 1'b0; req_addr[0 +: AW] = 19'd50; req[0] = 1'b1;
    @(negedge clk);
    check("col_gnt0", 32'(gnt), 32'd0);
    check("col_addr0", 32'(ram_addr), 32'd2000);
    pix_tick = 1'b0;
    @(negedge clk);
    check("col_gnt1", 32'(gnt), 32'b0001);
    check("col_addr1", 32'(ram_addr), 32'd50);
    req[0] = 1'b0;
    @(negedge clk);
    check("col_vga_valid", 32'(vga_valid), 32'd1);
    check("col_vga_data", 32'(vga_data), 32'h1D0);
    @(negedge clk);
    check("col_rvalid", 32'(rvalid), 32'd1);
    check("col_rdata", 32'(rdata), 32'd50);
    check("col_rid", 32'(rvalid_id), 32'd0);
    repeat (3) @(negedge clk);

    // Out-of-range write and read.
    issue(1, 1'b1, 19'd307200, 9'h0AA, g, e, w);
    check("oor_gnt", 32'(g), 32'b0010);
    check("oor_err", 32'(e), 32'd1);
    check("oor_wen", 32'(w), 32'd0);
    issue(1, 1'b0, 19'd307205, 9'h000, g, e, w);
    check("oor_rd_err", 32'(e), 32'd1);
    wait_rd(d, rid, lat);
    check("oor_rdata", 32'(d), 32'd0);
    check("oor_rid", 32'(rid), 32'd1);
    repeat (3) @(negedge clk);

    // Read in flight, reset during cycle 2.
    do_reset();
    issue(1, 1'b0, 19'd77, 9'h000, g, e, w);
    check("rst_rd_gnt", 32'(g), 32'b0010);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rvalid", 32'(rvalid), 32'd0);
    check("mid_gnt", 32'(gnt), 32'd0);
    check("mid_outs", 32'({ram_wen, vga_valid, addr_err, rvalid_id}), 32'd0);
    check("mid_addr", 32'(ram_addr), 32'd0);
    check("mid_data", 32'({ram_wdata, vga_data, rdata}), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rvalid_late", 32'(rvalid), 32'd0);
    req = '1;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
